cacheline_arbiter: RTL and testbench

- Shares the single burst-mode physical memory port (the parameterised memory: 4 beats x 64 bit = one 256-bit line) between the instruction cache (read-only) and the data cache (read/write).
- Sequences each whole-line transaction: grant, beat count, line assembly/disassembly, and one-cycle completion to the granted cache.
- Sits between the two caches and the memory model in the top-level wrapper.

---
 rtl/cacheline_arbiter_pkg.sv | 20 ++
 rtl/cacheline_arbiter_if.sv | 35 +++
 rtl/cacheline_arbiter_burst_shifter.sv | 46 ++++
 rtl/cacheline_arbiter.sv | 110 +++++++++++
 tb/tb_cacheline_arbiter.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cacheline_arbiter_pkg.sv
// Shared types and constants for the cacheline arbiter: burst geometry,
// FSM state encoding and grant identity.
package cacheline_arb_pkg;

  localparam int LINE_W      = 256;
  localparam int BEAT_W      = 64;
  localparam int BEATS       = LINE_W / BEAT_W;
  localparam int ADDR_W      = 32;
  localparam int OFFSET_BITS = 5;
  localparam int CNT_W       = $clog2(BEATS);

  typedef enum logic [2:0] {IDLE, I_RD, D_RD, D_WR, DONE} arb_state_t;
  typedef enum logic {GNT_I, GNT_D} grant_t;

  // Memory only understands whole lines, so the byte offset is dropped.
  function automatic logic [ADDR_W-1:0] line_align(input logic [ADDR_W-1:0] addr);
    return {addr[ADDR_W-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
  endfunction

endpackage

// File: rtl/cacheline_arbiter_if.sv
// Bundle of the icache, dcache and burst-memory signals around the arbiter.
// The slave side is the arbiter; the master side is the caches plus memory.
interface cacheline_arbiter_if;
  import cacheline_arb_pkg::*;

  logic              i_read;
  logic [ADDR_W-1:0] i_addr;
  logic [LINE_W-1:0] i_rdata;
  logic              i_resp;

  logic              d_read;
  logic              d_write;
  logic [ADDR_W-1:0] d_addr;
  logic [LINE_W-1:0] d_wdata;
  logic [LINE_W-1:0] d_rdata;
  logic              d_resp;

  logic              pmem_read;
  logic              pmem_write;
  logic [ADDR_W-1:0] pmem_addr;
  logic [BEAT_W-1:0] pmem_rdata;
  logic [BEAT_W-1:0] pmem_wdata;
  logic              pmem_resp;

  modport slave (
    input  i_read, i_addr, d_read, d_write, d_addr, d_wdata, pmem_rdata, pmem_resp,
    output i_rdata, i_resp, d_rdata, d_resp, pmem_read, pmem_write, pmem_addr, pmem_wdata
  );

  modport master (
    output i_read, i_addr, d_read, d_write, d_addr, d_wdata, pmem_rdata, pmem_resp,
    input  i_rdata, i_resp, d_rdata, d_resp, pmem_read, pmem_write, pmem_addr, pmem_wdata
  );

endinterface

// File: rtl/cacheline_arbiter_burst_shifter.sv
// Beat counter plus line buffer: assembles read beats into a line and
// presents the current beat of a loaded write line.
module burst_shifter
  import cacheline_arb_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load_line,
  input  logic [LINE_W-1:0] line_in,
  input  logic              capture_beat,
  input  logic              beat_ack,
  input  logic [BEAT_W-1:0] beat_in,
  output logic [BEAT_W-1:0] select_beat,
  output logic [LINE_W-1:0] line,
  output logic [CNT_W-1:0]  count
);

  logic [BEATS-1:0][BEAT_W-1:0] buf_q;
  logic [CNT_W-1:0]             count_q;

  // NOTE: the line buffer is cleared by reset like any other register, so
  // rdata never leaks stale data out of reset; it is small enough to afford it.
  // NOTE: non-blocking assignments keep every register updating from the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      buf_q   <= '0;
      count_q <= '0;
    end else begin
      if (load_line) begin
        buf_q <= line_in;
      end else if (capture_beat) begin
        buf_q[count_q] <= beat_in;
      end
      // The counter wraps back to 0 after the last beat, ready for the next line.
      if (beat_ack) begin
        count_q <= count_q + 1'b1;
      end
    end
  end

  assign select_beat = buf_q[count_q];
  assign line        = buf_q;
  assign count       = count_q;

endmodule

// File: rtl/cacheline_arbiter.sv
// Round-robin arbiter granting the burst memory port to the icache or dcache
// for one whole-line transaction at a time.
module cacheline_arbiter
  import cacheline_arb_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  cacheline_arbiter_if.slave  bus
);

  arb_state_t        state_q, state_d;
  grant_t            last_grant_q, last_grant_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  logic              load_line;
  logic              capture_beat;
  logic              beat_ack;
  logic [BEAT_W-1:0] cur_beat;
  logic [LINE_W-1:0] line;
  logic [CNT_W-1:0]  count;

  logic want_i, want_d, last_beat, in_rd, in_wr;

  assign want_i    = bus.i_read;
  assign want_d    = bus.d_read | bus.d_write;
  assign last_beat = (count == CNT_W'(BEATS - 1));

  burst_shifter u_shifter (
    .clk          (clk),
    .rst          (rst),
    .load_line    (load_line),
    .line_in      (bus.d_wdata),
    .capture_beat (capture_beat),
    .beat_ack     (beat_ack),
    .beat_in      (bus.pmem_rdata),
    .select_beat  (cur_beat),
    .line         (line),
    .count        (count)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      last_grant_q <= GNT_D;
      addr_q       <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      addr_q       <= addr_d;
    end
  end

  // last_grant doubles as the owner of the burst in flight, since it is
  // updated on every grant.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // through the case can leave one unassigned and infer a latch.
    state_d      = state_q;
    last_grant_d = last_grant_q;
    addr_d       = addr_q;
    load_line    = 1'b0;
    capture_beat = 1'b0;
    beat_ack     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (want_i && (!want_d || last_grant_q == GNT_D)) begin
          state_d      = I_RD;
          last_grant_d = GNT_I;
          addr_d       = line_align(bus.i_addr);
        end else if (want_d) begin
          state_d      = bus.d_write ? D_WR : D_RD;
          last_grant_d = GNT_D;
          addr_d       = line_align(bus.d_addr);
          load_line    = bus.d_write;
        end
      end
      I_RD, D_RD: begin
        if (bus.pmem_resp) begin
          capture_beat = 1'b1;
          beat_ack     = 1'b1;
          if (last_beat) state_d = DONE;
        end
      end
      D_WR: begin
        if (bus.pmem_resp) begin
          beat_ack = 1'b1;
          if (last_beat) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decode registered state only; pmem_resp never reaches a resp.
  assign in_rd = (state_q == I_RD) || (state_q == D_RD);
  assign in_wr = (state_q == D_WR);

  assign bus.pmem_read  = in_rd;
  assign bus.pmem_write = in_wr;
  assign bus.pmem_addr  = (in_rd || in_wr) ? addr_q : '0;
  assign bus.pmem_wdata = in_wr ? cur_beat : '0;

  assign bus.i_resp  = (state_q == DONE) && (last_grant_q == GNT_I);
  assign bus.d_resp  = (state_q == DONE) && (last_grant_q == GNT_D);
  assign bus.i_rdata = bus.i_resp ? line : '0;
  assign bus.d_rdata = bus.d_resp ? line : '0;

endmodule

// File: tb/tb_cacheline_arbiter.sv
// Directed bench: a burst-memory model and cache drivers feed the arbiter,
// expected responses go into queues and a monitor checks each resp pulse.
module tb_cacheline_arbiter;
  import cacheline_arb_pkg::*;

  typedef struct {
    logic              is_d;
    logic              care;
    logic [LINE_W-1:0] line;
  } exp_t;

  localparam logic [LINE_W-1:0] LINE1 =
    256'h4444444444444444_3333333333333333_2222222222222222_1111111111111111;
  localparam logic [LINE_W-1:0] LINE3 =
    256'hD0D0D0D0D0D0D0D0_C0C0C0C0C0C0C0C0_B0B0B0B0B0B0B0B0_A0A0A0A0A0A0A0A0;
  localparam logic [LINE_W-1:0] LINE4 =
    256'hDEADBEEF00000003_DEADBEEF00000002_DEADBEEF00000001_DEADBEEF00000000;
  localparam logic [LINE_W-1:0] WLINE =
    256'h0123456789ABCDEF_FEDCBA9876543210_0F1E2D3C4B5A6978_8796A5B4C3D2E1F0;

  logic clk;
  logic rst;
  cacheline_arbiter_if bus ();

  cacheline_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  exp_t              resp_q[$];
  logic [ADDR_W-1:0] exp_addr_q[$];
  logic [LINE_W-1:0] exp_wline_q[$];

  logic [BEAT_W-1:0] mem [logic [31:0]];
  int                gap          = 2;
  int                stall_beat   = -1;
  int                stall_cycles = 0;
  bit                m_busy       = 0;
  int                m_beat       = 0;
  int                m_wait       = 0;
  logic [ADDR_W-1:0] m_addr       = '0;
  logic [LINE_W-1:0] m_wline      = '0;
  logic [31:0]       m_key;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [LINE_W-1:0] act,
                       input logic [LINE_W-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic expect_resp(input logic is_d, input logic care, input logic [LINE_W-1:0] line);
    exp_t e;
    e.is_d = is_d;
    e.care = care;
    e.line = line;
    resp_q.push_back(e);
  endtask

  // Scoreboard monitor: every resp pulse must match the next expected entry.
  always @(negedge clk) begin
    if (rst && (bus.i_resp || bus.d_resp)) begin
      if (bus.i_resp && bus.d_resp) check("both_resp", 1, 0);
      if (resp_q.size() == 0) begin
        check("unexpected_resp", {bus.i_resp, bus.d_resp}, 0);
      end else begin
        exp_t e;
        e = resp_q.pop_front();
        check("resp_owner", bus.d_resp, e.is_d);
        if (e.care) check("resp_line", bus.d_resp ? bus.d_rdata : bus.i_rdata, e.line);
      end
    end
  end

  // Burst memory model: gap cycles before each beat, optional long stall.
  always @(negedge clk) begin
    if (!rst) begin
      m_busy         = 0;
      m_beat         = 0;
      bus.pmem_resp  = 1'b0;
      bus.pmem_rdata = '0;
    end else begin
      bus.pmem_resp = 1'b0;
      if (bus.pmem_read || bus.pmem_write) begin
        if (!m_busy) begin
          m_busy = 1;
          m_beat = 0;
          m_wait = gap;
          m_addr = bus.pmem_addr;
          if (exp_addr_q.size() == 0) check("unexpected_burst", bus.pmem_addr, 0);
          else check("pmem_addr", bus.pmem_addr, exp_addr_q.pop_front());
          if (bus.pmem_write) begin
            if (exp_wline_q.size() == 0) check("unexpected_write", 1, 0);
            else m_wline = exp_wline_q.pop_front();
          end
        end else begin
          check("pmem_addr_hold", bus.pmem_addr, m_addr);
        end
        if (m_beat < BEATS) begin
          if (bus.pmem_write) check("pmem_wdata", bus.pmem_wdata, m_wline[m_beat*BEAT_W +: BEAT_W]);
          if (m_wait == 0) begin
            bus.pmem_resp = 1'b1;
            m_key = m_addr + 32'(m_beat * 8);
            if (bus.pmem_read) bus.pmem_rdata = mem.exists(m_key) ? mem[m_key] : '0;
            else mem[m_key] = bus.pmem_wdata;
            m_beat++;
            m_wait = (m_beat == stall_beat) ? stall_cycles : gap;
          end else begin
            m_wait--;
          end
        end
      end else begin
        if (m_busy && m_beat != BEATS) check("burst_dropped", m_beat, BEATS);
        m_busy = 0;
      end
    end
  end

  task automatic wait_i();
    bit seen = 0;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (bus.i_resp) begin
        seen = 1;
        break;
      end
    end
    if (!seen) check("i_resp_timeout", 0, 1);
    bus.i_read = 1'b0;
  endtask

  task automatic wait_d();
    bit seen = 0;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (bus.d_resp) begin
        seen = 1;
        break;
      end
    end
    if (!seen) check("d_resp_timeout", 0, 1);
    bus.d_read  = 1'b0;
    bus.d_write = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < BEATS; k++) begin
      mem[32'h1000 + 32'(k*8)] = LINE1[k*BEAT_W +: BEAT_W];
      mem[32'h3000 + 32'(k*8)] = LINE3[k*BEAT_W +: BEAT_W];
      mem[32'h4000 + 32'(k*8)] = LINE4[k*BEAT_W +: BEAT_W];
    end

    // Reset held with both caches requesting: nothing may move.
    rst         = 1'b0;
    bus.i_read  = 1'b1;
    bus.i_addr  = 32'h0000_1004;
    bus.d_read  = 1'b1;
    bus.d_write = 1'b0;
    bus.d_addr  = 32'h0000_3000;
    bus.d_wdata = '0;
    repeat (5) begin
      @(negedge clk);
      check("reset_ctrl", {bus.i_resp, bus.d_resp, bus.pmem_read, bus.pmem_write}, 0);
      check("reset_bus", {bus.pmem_addr, bus.pmem_wdata}, 0);
      check("reset_rdata", bus.i_rdata | bus.d_rdata, 0);
    end

    // Both pending with last_grant=D: icache first, dcache right after.
    expect_resp(1'b0, 1'b1, LINE1);
    expect_resp(1'b1, 1'b1, LINE3);
    exp_addr_q.push_back(32'h0000_1000);
    exp_addr_q.push_back(32'h0000_3000);
    rst = 1'b1;
    @(negedge clk);
    check("grant_after_reset", {bus.pmem_read, bus.pmem_addr}, {1'b1, 32'h0000_1000});
    fork
      wait_i();
      wait_d();
    join
    @(negedge clk);

    // Lone icache read with low address bits set; last_grant becomes I.
    expect_resp(1'b0, 1'b1, LINE1);
    exp_addr_q.push_back(32'h0000_1000);
    bus.i_addr = 32'h0000_101F;
    bus.i_read = 1'b1;
    wait_i();
    @(negedge clk);

    // Both pending with last_grant=I: dcache goes first this time.
    expect_resp(1'b1, 1'b1, LINE1);
    expect_resp(1'b0, 1'b1, LINE3);
    exp_addr_q.push_back(32'h0000_1000);
    exp_addr_q.push_back(32'h0000_3000);
    bus.i_addr = 32'h0000_3000;
    bus.d_addr = 32'h0000_1000;
    bus.i_read = 1'b1;
    bus.d_read = 1'b1;
    fork
      wait_i();
      wait_d();
    join
    @(negedge clk);

    // Line write: beats in order, each held until its ack.
    gap = 1;
    expect_resp(1'b1, 1'b0, '0);
    exp_addr_q.push_back(32'h0000_2000);
    exp_wline_q.push_back(WLINE);
    bus.d_addr  = 32'h0000_2000;
    bus.d_wdata = WLINE;
    bus.d_write = 1'b1;
    wait_d();
    bus.d_wdata = '0;
    @(negedge clk);
    for (int k = 0; k < BEATS; k++)
      check("mem_after_write", mem.exists(32'h2000 + 32'(k*8)) ? mem[32'h2000 + 32'(k*8)] : '0,
            WLINE[k*BEAT_W +: BEAT_W]);

    // Read the written line back through the dcache path.
    gap = 0;
    expect_resp(1'b1, 1'b1, WLINE);
    exp_addr_q.push_back(32'h0000_2000);
    bus.d_addr = 32'h0000_2010;
    bus.d_read = 1'b1;
    wait_d();
    @(negedge clk);

    // 20-cycle stall before beat 2: address and read held, no early resp.
    gap          = 1;
    stall_beat   = 2;
    stall_cycles = 20;
    expect_resp(1'b0, 1'b1, LINE4);
    exp_addr_q.push_back(32'h0000_4000);
    bus.i_addr = 32'h0000_4008;
    bus.i_read = 1'b1;
    wait_i();
    stall_beat = -1;
    @(negedge clk);

    // Reset after beat 2 of a dcache read: abandoned, no d_resp.
    gap = 2;
    exp_addr_q.push_back(32'h0000_5000);
    bus.d_addr = 32'h0000_5008;
    bus.d_read = 1'b1;
    for (int n = 0; n < 100 && !(m_busy && m_beat == 3); n++) @(negedge clk);
    check("mid_burst_reached", m_beat, 3);
    @(posedge clk);
    #1;
    rst        = 1'b0;
    bus.d_read = 1'b0;
    @(negedge clk);
    check("abort_ctrl", {bus.pmem_read, bus.pmem_write, bus.i_resp, bus.d_resp}, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("abort_idle", {bus.pmem_read, bus.d_resp}, 0);

    // Fresh transaction after the abort must assemble from beat 0.
    expect_resp(1'b0, 1'b1, LINE1);
    exp_addr_q.push_back(32'h0000_1000);
    bus.i_addr = 32'h0000_1004;
    bus.i_read = 1'b1;
    wait_i();
    repeat (3) @(negedge clk);

    check("resp_queue_drained", resp_q.size(), 0);
    check("addr_queue_drained", exp_addr_q.size(), 0);
    check("wline_queue_drained", exp_wline_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
